// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave with NUM_REGS x DATA_WIDTH read/write registers and
// burst auto-increment. Everything runs on clk; SCK, MOSI and CS_N are synchronised
// and SCK is edge-detected, so no logic is clocked by SCK.
//
// Ports:
//   clk        system clock (>= 4x SCK)
//   RST_N      asynchronous active-low reset
//   SCK        SPI clock, idle low
//   MOSI       SPI data in, sampled on synchronised SCK rise
//   CS_N       SPI chip select, active low
//   MISO       registered SPI data out, updated on synchronised SCK fall
//   MISO_OE    high while synchronised CS_N is low
//   regs_flat  register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse   1-cycle strobe when a register write commits
//   wr_addr    address of the last committed write
//   frame_err  1-cycle strobe when CS_N rises mid-word
module spi_reg_bank #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           RST_N,
  input  logic                           SCK,
  input  logic                           MOSI,
  input  logic                           CS_N,
  output logic                           MISO,
  output logic                           MISO_OE,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           wr_pulse,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic                           frame_err
);

  // The shifter must hold a full command byte even for narrow data words.
  localparam int unsigned ShiftW = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam int unsigned CntW   = $clog2(ShiftW);
  localparam int unsigned TxCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [ADDR_WIDTH:0]   NumRegsA = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [CntW-1:0]       CmdLast  = CntW'(7);
  localparam logic [CntW-1:0]       DataLast = CntW'(DATA_WIDTH - 1);
  localparam logic [TxCntW-1:0]     TxLast   = TxCntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // Synchronisers
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, mosi_s, cs_s, sck_rise, sck_fall;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;  // deselected, so MISO_OE stays low out of reset
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
      sck_prev_q  <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Frame state
  state_e                               state_q, state_d;
  logic [CntW-1:0]                      bit_cnt_q, bit_cnt_d;
  logic [ShiftW-2:0]                    shift_q, shift_d;
  logic                                 rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [DATA_WIDTH-1:0]                tx_q, tx_d;
  logic [TxCntW-1:0]                    tx_cnt_q, tx_cnt_d;
  logic                                 miso_q, miso_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic                                 wr_pulse_q, wr_pulse_d;
  logic [ADDR_WIDTH-1:0]                wr_addr_q, wr_addr_d;
  logic                                 frame_err_q, frame_err_d;

  // The bit arriving on this rise completes the word together with the stored bits.
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] rx_word, rd_word;
  logic                  addr_in_range;

  assign cmd_addr      = ADDR_WIDTH'({shift_q, mosi_s});
  assign rx_word       = DATA_WIDTH'({shift_q, mosi_s});
  assign addr_in_range = ({1'b0, addr_q} < NumRegsA);
  assign rd_word       = addr_in_range ? regs_q[addr_q] : '0;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    if (cs_s) begin
      // Deselect wins over any coincident SCK edge; a partial word is dropped.
      if (state_q != StIdle && bit_cnt_q != '0) frame_err_d = 1'b1;
      state_d   = StIdle;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StCmd;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end
        StCmd: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            shift_d = {shift_q[ShiftW-3:0], mosi_s};
            if (bit_cnt_q == CmdLast) begin
              rw_d      = shift_q[6];
              addr_d    = cmd_addr;
              bit_cnt_d = '0;
              tx_cnt_d  = '0;
              state_d   = StData;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (sck_rise) begin
            shift_d = {shift_q[ShiftW-3:0], mosi_s};
            if (bit_cnt_q == DataLast) begin
              bit_cnt_d = '0;
              if (rw_q && addr_in_range) begin
                regs_d[addr_q] = rx_word;
                wr_pulse_d     = 1'b1;
                wr_addr_d      = addr_q;
              end
              addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // Reads: tx_cnt==0 marks a word boundary, where the current address is loaded.
          if (sck_fall && !rw_q) begin
            if (tx_cnt_q == '0) begin
              miso_d = rd_word[DATA_WIDTH-1];
              tx_d   = {rd_word[DATA_WIDTH-2:0], 1'b0};
            end else begin
              miso_d = tx_q[DATA_WIDTH-1];
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            tx_cnt_d = (tx_cnt_q == TxLast) ? '0 : tx_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      tx_q        <= '0;
      tx_cnt_q    <= '0;
      miso_q      <= 1'b0;
      regs_q      <= '0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      tx_cnt_q    <= tx_cnt_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_OE   = ~cs_s;
  assign regs_flat = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
